tap_window_avg: RTL and testbench
=================================

Name: tap_window_avg

Overview:
- Downstream consumer of the 4-stage 8-bit sample shift register.
- Takes the four parallel taps (newest = Tap0, oldest = Tap3) plus a per-shift strobe.
- Once the window has filled, produces the registered 4-tap sum, average and peak for each new window.
- Output uses a valid/ready handshake with a one-entry holding register and a sticky overrun flag.

Parameters:
- WIDTH, 8, bit width of each tap sample (unsigned).
- THRESH, 8'h80, compare level for the Above flag; WIDTH bits.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Clear  input  1  synchronous flush: restart fill, drop pending result, clear Overrun.
- TapValid  input  1  Tap0..Tap3 hold a freshly shifted window this cycle.
- Tap0  input  WIDTH  newest sample.
- Tap1  input  WIDTH  sample delayed 1 shift.
- Tap2  input  WIDTH  sample delayed 2 shifts.
- Tap3  input  WIDTH  oldest sample.
- OutReady  input  1  consumer accepts the result when high with OutValid.
- OutValid  output  1  result registers hold an unaccepted result.
- Sum  output  WIDTH+2  Tap0+Tap1+Tap2+Tap3, full precision.
- Avg  output  WIDTH  Sum/4 (rounding per optional feature).
- Peak  output  WIDTH  max(Tap0..Tap3).
- Above  output  1  Avg >= THRESH.
- Overrun  output  1  sticky: a qualified window was dropped.
- Filled  output  1  high once 4 windows have been seen since Reset/Clear.

Behaviour:
- All state updates on posedge Clock only. Reset is synchronous, active-high.
- Reset forces all of the following; all outputs are registered:
  - state=FILL, fill count=0
  - OutValid=0, Sum=0, Avg=0, Peak=0, Above=0, Overrun=0, Filled=0
- FSM has 2 states:
  - FILL: 2-bit count c. Each TapValid increments c. A TapValid seen with c==3 is a qualifying window and moves to RUN (Filled=1 from the next cycle).
  - RUN: every TapValid is a qualifying window. RUN is left only via Reset or Clear.
- Load condition: qualifying window AND (OutValid==0 OR OutReady==1).
  - On load, the next cycle has OutValid=1 and Sum/Avg/Peak/Above computed from the taps sampled at that edge.
  - Latency is 1 cycle from TapValid to OutValid.
- Handshake:
  - Transfer occurs when OutValid && OutReady.
  - After a transfer with no simultaneous load, OutValid=0.
  - A transfer and a load in the same cycle gives back-to-back results, OutValid stays 1, and no bubble occurs.
  - Result registers must hold stable while OutValid && !OutReady.
- Overrun: a qualifying window with OutValid==1 && OutReady==0 is dropped.
  - The held result is unchanged and Overrun is set to 1.
  - Overrun stays set until Reset or Clear.
- Non-qualifying TapValid (FILL, c<3) never touches the output registers or OutValid.
- TapValid low: no change to count or results; handshake still proceeds.
- Clear (priority below Reset, above everything else) forces:
  - state=FILL, c=0, Filled=0, OutValid=0, Overrun=0
  - A TapValid in the same cycle is ignored and not counted.
  - Sum/Avg/Peak/Above keep their last values but are not valid.
- Arithmetic:
  - Sum is zero-extended, WIDTH+2 bits, no overflow possible (max 4*255=1020 for WIDTH=8).
  - Peak is an unsigned compare. Above uses the post-rounding Avg.

Optional Feature:
- Macro: TAP_WINDOW_AVG_ROUND_EN.
- Defined: Avg = (Sum+2)>>2, round-half-up. Saturate to all-ones if the result exceeds WIDTH bits (Sum>=1022 for WIDTH=8 gives 255).
- Undefined: Avg = Sum>>2, truncation.
- Sum, Peak and the handshake are identical in both builds.

Test Plan:
- Reset, then 3 TapValid pulses -> OutValid stays 0, Filled=0. 4th pulse with taps 10,20,30,40 -> next cycle OutValid=1, Sum=100, Avg=25, Peak=40, Above=0, Filled=1.
- OutReady held 1, TapValid every cycle in RUN with Tap0..3 all 200 -> one result per cycle, no bubble, Sum=800, Avg=200, Above=1, Overrun=0.
- Hold OutReady=0 with a result pending, assert TapValid with new taps -> held result unchanged, Overrun=1. Raise OutReady -> one transfer, OutValid=0, Overrun stays 1.
- Taps 1,1,1,2 (Sum=5) -> Avg=1 without macro, Avg=1 with macro. Taps 1,1,2,2 (Sum=6) -> Avg=1 without, Avg=2 with. Taps all 255 with macro -> Avg=255 (saturated).
- In RUN with OutValid=1, assert Clear together with TapValid -> next cycle OutValid=0, Filled=0, Overrun=0. Four further TapValid are required before the next OutValid.
- Assert Reset mid-stream with OutValid=1 and OutReady=0 -> next cycle all outputs zero and state FILL. The fill count restarts from 0.

Source files
------------

// File: rtl/tap_window_avg.sv
// 4-tap window sum/average/peak, 1-cycle latency, one-entry valid/ready output; a window that arrives while a result is stalled is dropped and sets sticky Overrun.
// Optional TAP_WINDOW_AVG_ROUND_EN selects round-half-up averaging (default: truncation).
module tap_window_avg #(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] THRESH = WIDTH'(8'h80)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Clear,
  input  logic             TapValid,
  input  logic [WIDTH-1:0] Tap0,
  input  logic [WIDTH-1:0] Tap1,
  input  logic [WIDTH-1:0] Tap2,
  input  logic [WIDTH-1:0] Tap3,
  input  logic             OutReady,
  output logic             OutValid,
  output logic [WIDTH+1:0] Sum,
  output logic [WIDTH-1:0] Avg,
  output logic [WIDTH-1:0] Peak,
  output logic             Above,
  output logic             Overrun,
  output logic             Filled
);

  typedef enum logic {FILL, RUN} state_t;

  state_t           state;
  logic [1:0]       cnt;
  logic [WIDTH+1:0] sum_c;
  logic [WIDTH-1:0] avg_c;
  logic [WIDTH-1:0] pk01, pk23, peak_c;
  logic             qual, load;

  assign sum_c = {2'b00, Tap0} + {2'b00, Tap1} + {2'b00, Tap2} + {2'b00, Tap3};

`ifdef TAP_WINDOW_AVG_ROUND_EN
  // Max sum plus 2 still fits WIDTH+2 bits, and its top WIDTH bits are all-ones,
  // so the rounded result saturates naturally without a separate clamp.
  logic [WIDTH+1:0] rnd_c;
  assign rnd_c = sum_c + (WIDTH+2)'(2);
  assign avg_c = rnd_c[WIDTH+1:2];
`else
  assign avg_c = sum_c[WIDTH+1:2];
`endif

  assign pk01   = (Tap0 > Tap1) ? Tap0 : Tap1;
  assign pk23   = (Tap2 > Tap3) ? Tap2 : Tap3;
  assign peak_c = (pk01 > pk23) ? pk01 : pk23;

  assign qual = TapValid && ((state == RUN) || (cnt == 2'd3));
  assign load = qual && (!OutValid || OutReady);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= FILL;
      cnt      <= 2'd0;
      OutValid <= 1'b0;
      Sum      <= '0;
      Avg      <= '0;
      Peak     <= '0;
      Above    <= 1'b0;
      Overrun  <= 1'b0;
      Filled   <= 1'b0;
    end else if (Clear) begin
      // Result registers keep their contents; only validity is withdrawn.
      state    <= FILL;
      cnt      <= 2'd0;
      OutValid <= 1'b0;
      Overrun  <= 1'b0;
      Filled   <= 1'b0;
    end else begin
      if (TapValid && (state == FILL)) begin
        cnt <= cnt + 2'd1;
        if (cnt == 2'd3) begin
          state  <= RUN;
          Filled <= 1'b1;
        end
      end

      if (load) begin
        OutValid <= 1'b1;
        Sum      <= sum_c;
        Avg      <= avg_c;
        Peak     <= peak_c;
        Above    <= (avg_c >= THRESH);
      end else if (OutValid && OutReady) begin
        OutValid <= 1'b0;
      end

      if (qual && OutValid && !OutReady) begin
        Overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tap_window_avg.sv
// Directed bench for tap_window_avg with a result scoreboard; honours TAP_WINDOW_AVG_ROUND_EN.
module tb_tap_window_avg;

  typedef struct {
    int sum;
    int avg;
    int peak;
    int above;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset, clear, tap_valid, out_ready;
  logic [7:0] tap0, tap1, tap2, tap3;
  logic       out_valid, above, overrun, filled;
  logic [9:0] sum;
  logic [7:0] avg, peak;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  tap_window_avg #(.WIDTH(8), .THRESH(8'h80)) dut (
    .Clock(clock), .Reset(reset), .Clear(clear), .TapValid(tap_valid),
    .Tap0(tap0), .Tap1(tap1), .Tap2(tap2), .Tap3(tap3),
    .OutReady(out_ready), .OutValid(out_valid), .Sum(sum), .Avg(avg),
    .Peak(peak), .Above(above), .Overrun(overrun), .Filled(filled)
  );

  function automatic exp_t model(input int a, input int b, input int c, input int d);
    exp_t e;
    int   pk;
    e.sum = a + b + c + d;
`ifdef TAP_WINDOW_AVG_ROUND_EN
    e.avg = (e.sum + 2) / 4;
    if (e.avg > 255) e.avg = 255;
`else
    e.avg = e.sum / 4;
`endif
    pk = a;
    if (b > pk) pk = b;
    if (c > pk) pk = c;
    if (d > pk) pk = d;
    e.peak  = pk;
    e.above = (e.avg >= 128) ? 1 : 0;
    return e;
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_front(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=no-entry expected=scoreboard-entry", tag);
    end else begin
      e = sb[0];
      chk({tag, ".sum"},   32'(sum),   32'(e.sum));
      chk({tag, ".avg"},   32'(avg),   32'(e.avg));
      chk({tag, ".peak"},  32'(peak),  32'(e.peak));
      chk({tag, ".above"}, 32'(above), 32'(e.above));
    end
  endtask

  task automatic set_taps(input int a, input int b, input int c, input int d);
    tap0 = 8'(a);
    tap1 = 8'(b);
    tap2 = 8'(c);
    tap3 = 8'(d);
  endtask

  // Drive one qualifying window; pop_prev says the previously held result transfers this cycle.
  task automatic load_win(input string tag, input int a, input int b, input int c, input int d,
                          input logic ready, input logic pop_prev);
    tap_valid = 1'b1;
    out_ready = ready;
    set_taps(a, b, c, d);
    sb.push_back(model(a, b, c, d));
    cyc();
    tap_valid = 1'b0;
    if (pop_prev) void'(sb.pop_front());
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    check_front(tag);
  endtask

  task automatic fill3(input string tag);
    for (int i = 0; i < 3; i++) begin
      tap_valid = 1'b1;
      set_taps(5, 5, 5, 5);
      cyc();
      tap_valid = 1'b0;
      chk({tag, ".valid"},  32'(out_valid), 32'd0);
      chk({tag, ".filled"}, 32'(filled),    32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clear = 1'b0; tap_valid = 1'b0; out_ready = 1'b0;
    set_taps(0, 0, 0, 0);
    cyc(); cyc();
    reset = 1'b0;
    chk("rst.valid",   32'(out_valid), 32'd0);
    chk("rst.sum",     32'(sum),       32'd0);
    chk("rst.avg",     32'(avg),       32'd0);
    chk("rst.peak",    32'(peak),      32'd0);
    chk("rst.above",   32'(above),     32'd0);
    chk("rst.overrun", 32'(overrun),   32'd0);
    chk("rst.filled",  32'(filled),    32'd0);

    // Fill: three windows produce nothing, the fourth qualifies.
    fill3("fill");
    load_win("first", 10, 20, 30, 40, 1'b0, 1'b0);
    chk("first.filled", 32'(filled), 32'd1);

    // Streaming with OutReady high: back-to-back, no bubble.
    for (int i = 0; i < 4; i++) begin
      load_win("stream", 200, 200, 200, 200, 1'b1, 1'b1);
      chk("stream.overrun", 32'(overrun), 32'd0);
    end
    out_ready = 1'b1;
    cyc();
    void'(sb.pop_front());
    chk("drain1.valid", 32'(out_valid), 32'd0);

    // Stall: second window dropped, held result stable, sticky overrun.
    load_win("held", 7, 8, 9, 10, 1'b0, 1'b0);
    tap_valid = 1'b1;
    set_taps(100, 100, 100, 100);
    cyc();
    tap_valid = 1'b0;
    chk("drop.valid",   32'(out_valid), 32'd1);
    chk("drop.overrun", 32'(overrun),   32'd1);
    check_front("drop");
    out_ready = 1'b1;
    cyc();
    void'(sb.pop_front());
    chk("xfer.valid",   32'(out_valid), 32'd0);
    chk("xfer.overrun", 32'(overrun),   32'd1);

    // Rounding, saturation and threshold boundary.
    load_win("s5",   1, 1, 1, 2,         1'b1, 1'b0);
    load_win("s6",   1, 1, 2, 2,         1'b1, 1'b1);
    load_win("s1020", 255, 255, 255, 255, 1'b1, 1'b1);
    load_win("t128", 128, 128, 128, 128, 1'b1, 1'b1);
    load_win("t127", 127, 127, 127, 127, 1'b1, 1'b1);
    out_ready = 1'b1;
    cyc();
    void'(sb.pop_front());
    chk("drain2.valid", 32'(out_valid), 32'd0);

    // Clear with a simultaneous TapValid while a result is pending.
    load_win("preclr", 50, 50, 50, 50, 1'b0, 1'b0);
    clear = 1'b1;
    tap_valid = 1'b1;
    set_taps(60, 60, 60, 60);
    cyc();
    clear = 1'b0;
    tap_valid = 1'b0;
    sb.delete();
    chk("clr.valid",   32'(out_valid), 32'd0);
    chk("clr.filled",  32'(filled),    32'd0);
    chk("clr.overrun", 32'(overrun),   32'd0);
    chk("clr.sumkept", 32'(sum),       32'd200);
    fill3("clrfill");
    load_win("postclr", 3, 6, 9, 12, 1'b0, 1'b0);
    chk("postclr.filled", 32'(filled), 32'd1);

    // Reset mid-stream with a stalled result and overrun set.
    tap_valid = 1'b1;
    set_taps(9, 9, 9, 9);
    cyc();
    chk("prerst.overrun", 32'(overrun), 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    tap_valid = 1'b0;
    sb.delete();
    chk("mrst.valid",   32'(out_valid), 32'd0);
    chk("mrst.sum",     32'(sum),       32'd0);
    chk("mrst.avg",     32'(avg),       32'd0);
    chk("mrst.peak",    32'(peak),      32'd0);
    chk("mrst.above",   32'(above),     32'd0);
    chk("mrst.overrun", 32'(overrun),   32'd0);
    chk("mrst.filled",  32'(filled),    32'd0);
    fill3("rstfill");
    load_win("postrst", 4, 3, 2, 1, 1'b1, 1'b0);
    out_ready = 1'b1;
    cyc();
    void'(sb.pop_front());
    chk("drain3.valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
